// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data RAM port between the CPU MEM stage
// and the debug/loader port, with registered read return.
module dmem_arbiter #(
    parameter int ADDR_SIZE  = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        CLR_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic        cpu_byte,
    input  logic        cpu_half,
    input  logic        cpu_uext,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    output logic        cpu_misalign,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic [31:0] dbg_rdata,
    output logic        dbg_rvalid,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_data_in,
    output logic        ram_MemWrite,
    output logic        ram_Byte,
    output logic        ram_Half,
    output logic        ram_UnsignedExt,
    input  logic [31:0] ram_data_out,
    input  logic        clr_misalign
);

    typedef enum logic [1:0] {
        OWN_IDLE,
        OWN_CPU,
        OWN_DBG
    } owner_t;

    localparam logic [31:0] AMASK =
        32'((64'd1 << ADDR_SIZE) - 64'd1);
    localparam logic [3:0]  SMAX  = 4'(STARVE_MAX);

    owner_t     owner_q;
    owner_t     owner_d;
    logic [3:0] starve_cnt;
    logic       starve_hit;
    logic       cpu_gnt;
    logic       cpu_rd;
    logic       dbg_rd;
    logic       cpu_mis;
    logic       mem_we;

    // Arbitration: CPU wins unless debug has waited STARVE_MAX cycles.
    always_comb begin
        starve_hit = (starve_cnt == SMAX);
        dbg_gnt    = dbg_req & (~cpu_req | starve_hit);
        cpu_gnt    = cpu_req & ~dbg_gnt;
        cpu_stall  = cpu_req & ~cpu_gnt;
        cpu_rd     = cpu_gnt & ~cpu_we;
        dbg_rd     = dbg_gnt & ~dbg_we;
        cpu_mis    = ~cpu_byte &
                     (cpu_half ? cpu_addr[0]
                               : (cpu_addr[1:0] != 2'b00));
    end

    // RAM port mux; idle cycles and reset never write.
    always_comb begin
        ram_addr        = '0;
        ram_data_in     = '0;
        ram_Byte        = 1'b0;
        ram_Half        = 1'b0;
        ram_UnsignedExt = 1'b0;
        mem_we          = 1'b0;
        unique case (1'b1)
            cpu_gnt: begin
                ram_addr        = cpu_addr & AMASK;
                ram_data_in     = cpu_wdata;
                ram_Byte        = cpu_byte;
                ram_Half        = cpu_half;
                ram_UnsignedExt = cpu_uext;
                mem_we          = cpu_we;
            end
            dbg_gnt: begin
                ram_addr        = dbg_addr & AMASK;
                ram_data_in     = dbg_wdata;
                mem_we          = dbg_we;
            end
            default: ;
        endcase
        ram_MemWrite = mem_we & CLR_n;
    end

    // Count consecutive denied debug cycles, saturating.
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            starve_cnt <= '0;
        end else if (~dbg_req | dbg_gnt) begin
            starve_cnt <= '0;
        end else if (!starve_hit) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Owner state register.
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            owner_q <= OWN_IDLE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Owner next state: who gets read data next cycle.
    always_comb begin
        owner_d = OWN_IDLE;
        if (cpu_rd) begin
            owner_d = OWN_CPU;
        end else if (dbg_rd) begin
            owner_d = OWN_DBG;
        end
    end

    assign cpu_rvalid = (owner_q == OWN_CPU);
    assign dbg_rvalid = (owner_q == OWN_DBG);

    // Capture RAM read data into the reading port's register.
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            if (cpu_rd) begin
                cpu_rdata <= ram_data_out;
            end
            if (dbg_rd) begin
                dbg_rdata <= ram_data_out;
            end
        end
    end

    // Sticky misalign flag; a new event beats the clear.
    always_ff @(posedge clk or negedge CLR_n) begin
        if (!CLR_n) begin
            cpu_misalign <= 1'b0;
        end else if (cpu_gnt & cpu_mis) begin
            cpu_misalign <= 1'b1;
        end else if (clr_misalign) begin
            cpu_misalign <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter
// with a byte RAM and a behavioural reference model.
module tb_dmem_arbiter;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        CLR_n;
    logic        cpu_req, cpu_we, cpu_byte, cpu_half, cpu_uext;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid, cpu_misalign;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt;
    logic [31:0] dbg_rdata;
    logic        dbg_rvalid;
    logic [31:0] ram_addr, ram_data_in;
    logic        ram_MemWrite, ram_Byte, ram_Half, ram_UnsignedExt;
    logic [31:0] ram_data_out;
    logic        clr_misalign;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_SIZE(8), .STARVE_MAX(SM)) dut (
        .clk(clk), .CLR_n(CLR_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_byte(cpu_byte), .cpu_half(cpu_half),
        .cpu_uext(cpu_uext), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
        .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .cpu_misalign(cpu_misalign),
        .dbg_req(dbg_req), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
        .dbg_rvalid(dbg_rvalid),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_MemWrite(ram_MemWrite), .ram_Byte(ram_Byte),
        .ram_Half(ram_Half), .ram_UnsignedExt(ram_UnsignedExt),
        .ram_data_out(ram_data_out),
        .clr_misalign(clr_misalign)
    );

    typedef struct {
        int          due;
        logic [31:0] d;
    } rsp_t;

    rsp_t       cq[$];
    rsp_t       dq[$];
    int         nchk = 0;
    int         nerr = 0;
    int         cyc  = 0;
    logic [7:0] ram_m [256];
    logic [7:0] ref_m [256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string n, input logic a, input logic e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %b want %b", n, cyc, a, e);
        end
    endtask

    task automatic chk32(input string n, input logic [31:0] a,
                         input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %h want %h", n, cyc, a, e);
        end
    endtask

    // Byte RAM seen through the DUT's ram_* pins.
    logic [7:0]  ra;
    logic [7:0]  r_b;
    logic [15:0] r_h;
    logic [31:0] r_w;
    assign ra  = ram_addr[7:0];
    assign r_b = ram_m[ra];
    assign r_h = {ram_m[{ra[7:1], 1'b1}], ram_m[{ra[7:1], 1'b0}]};
    assign r_w = {ram_m[{ra[7:2], 2'd3}], ram_m[{ra[7:2], 2'd2}],
                  ram_m[{ra[7:2], 2'd1}], ram_m[{ra[7:2], 2'd0}]};
    assign ram_data_out =
        ram_Byte ? (ram_UnsignedExt ? {24'h0, r_b}
                                    : {{24{r_b[7]}}, r_b}) :
        ram_Half ? (ram_UnsignedExt ? {16'h0, r_h}
                                    : {{16{r_h[15]}}, r_h}) : r_w;

    initial begin
        for (int i = 0; i < 256; i++) ram_m[i] = 8'(i * 37 + 5);
        forever begin
            @(posedge clk);
            if (ram_MemWrite) begin
                if (ram_Byte) begin
                    ram_m[ra] <= ram_data_in[7:0];
                end else if (ram_Half) begin
                    ram_m[{ra[7:1], 1'b1}] <= ram_data_in[15:8];
                    ram_m[{ra[7:1], 1'b0}] <= ram_data_in[7:0];
                end else begin
                    ram_m[{ra[7:2], 2'd3}] <= ram_data_in[31:24];
                    ram_m[{ra[7:2], 2'd2}] <= ram_data_in[23:16];
                    ram_m[{ra[7:2], 2'd1}] <= ram_data_in[15:8];
                    ram_m[{ra[7:2], 2'd0}] <= ram_data_in[7:0];
                end
            end
        end
    end

    // Reference memory access rules (little endian, size-aligned).
    function automatic logic [31:0] ref_ld(input int a, input logic b,
                                           input logic h, input logic u);
        int          p;
        logic [31:0] v;
        if (b) begin
            v = {24'h0, ref_m[a]};
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (h) begin
            p = a - (a % 2);
            v = {16'h0, ref_m[p + 1], ref_m[p]};
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            p = a - (a % 4);
            v = {ref_m[p + 3], ref_m[p + 2], ref_m[p + 1], ref_m[p]};
        end
        return v;
    endfunction

    task automatic ref_st(input int a, input logic b, input logic h,
                          input logic [31:0] d);
        int p;
        if (b) begin
            ref_m[a] = d[7:0];
        end else if (h) begin
            p = a - (a % 2);
            ref_m[p] = d[7:0];
            ref_m[p + 1] = d[15:8];
        end else begin
            p = a - (a % 4);
            for (int k = 0; k < 4; k++) ref_m[p + k] = d[8*k +: 8];
        end
    endtask

    // Reference model: grants, misalign flag, memory, expected reads.
    int   dwait = 0;
    logic exp_mis = 1'b0;
    initial begin
        logic cg, dg, mis;
        int   a;
        for (int i = 0; i < 256; i++) ref_m[i] = 8'(i * 37 + 5);
        forever begin
            @(negedge clk);
            if (!CLR_n) begin
                dwait   = 0;
                exp_mis = 1'b0;
            end
            dg = dbg_req && (!cpu_req || dwait >= SM);
            cg = cpu_req && !dg;
            chk1("cpu_stall", cpu_stall, cpu_req && !cg);
            chk1("dbg_gnt", dbg_gnt, dg);
            chk1("cpu_misalign", cpu_misalign, exp_mis);
            chk1("ram_addr_hi", |ram_addr[31:8], 1'b0);
            if (!CLR_n) chk1("we_in_reset", ram_MemWrite, 1'b0);
            if (CLR_n) begin
                a   = int'(cpu_addr[7:0]);
                mis = !cpu_byte &&
                      (cpu_half ? (a % 2 != 0) : (a % 4 != 0));
                if (cg && mis) exp_mis = 1'b1;
                else if (clr_misalign) exp_mis = 1'b0;
                if (cg) begin
                    if (cpu_we) ref_st(a, cpu_byte, cpu_half, cpu_wdata);
                    else cq.push_back('{cyc + 1,
                        ref_ld(a, cpu_byte, cpu_half, cpu_uext)});
                end
                if (dg) begin
                    a = int'(dbg_addr[7:0]);
                    if (dbg_we) ref_st(a, 1'b0, 1'b0, dbg_wdata);
                    else dq.push_back('{cyc + 1,
                        ref_ld(a, 1'b0, 1'b0, 1'b0)});
                end
                if (dbg_req && !dg) dwait = dwait + 1;
                else dwait = 0;
            end
        end
    end

    // Monitor: pops expected read returns when strobes are due.
    initial begin
        logic [31:0] ecr = '0;
        logic [31:0] edr = '0;
        logic        ev;
        forever begin
            @(negedge clk);
            if (!CLR_n) begin
                cq.delete();
                dq.delete();
                ecr = '0;
                edr = '0;
                chk1("cpu_rvalid_rst", cpu_rvalid, 1'b0);
                chk1("dbg_rvalid_rst", dbg_rvalid, 1'b0);
            end else begin
                ev = (cq.size() > 0) && (cq[0].due == cyc);
                chk1("cpu_rvalid", cpu_rvalid, ev);
                if (ev) begin
                    ecr = cq[0].d;
                    void'(cq.pop_front());
                end
                ev = (dq.size() > 0) && (dq[0].due == cyc);
                chk1("dbg_rvalid", dbg_rvalid, ev);
                if (ev) begin
                    edr = dq[0].d;
                    void'(dq.pop_front());
                end
            end
            chk32("cpu_rdata", cpu_rdata, ecr);
            chk32("dbg_rdata", dbg_rdata, edr);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_xfer(input logic we, input logic b, input logic h,
                            input logic u, input logic [31:0] ad,
                            input logic [31:0] wd);
        logic g;
        cpu_we = we; cpu_byte = b; cpu_half = h; cpu_uext = u;
        cpu_addr = ad; cpu_wdata = wd; cpu_req = 1'b1;
        g = 1'b0;
        for (int k = 0; k < 20 && !g; k++) begin
            @(negedge clk);
            g = !cpu_stall;
            @(posedge clk);
            #1;
        end
        chk1("cpu_grant_wait", g, 1'b1);
        cpu_req = 1'b0;
    endtask

    task automatic dbg_xfer(input logic we, input logic [31:0] ad,
                            input logic [31:0] wd);
        logic g;
        dbg_we = we; dbg_addr = ad; dbg_wdata = wd; dbg_req = 1'b1;
        g = 1'b0;
        for (int k = 0; k < 20 && !g; k++) begin
            @(negedge clk);
            g = dbg_gnt;
            @(posedge clk);
            #1;
        end
        chk1("dbg_grant_wait", g, 1'b1);
        dbg_req = 1'b0;
    endtask

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        logic cg, dgg;
        int   win, sz;
        CLR_n = 1'b0; clr_misalign = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0;
        cpu_half = 1'b0; cpu_uext = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        idle(2);
        CLR_n = 1'b1;
        idle(1);
        cpu_xfer(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF);
        cpu_xfer(1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        idle(1);
        cpu_xfer(1'b1, 1'b1, 1'b0, 1'b0, 32'h21, 32'h80);
        cpu_xfer(1'b0, 1'b1, 1'b0, 1'b0, 32'h21, 32'h0);
        cpu_xfer(1'b0, 1'b1, 1'b0, 1'b1, 32'h21, 32'h0);
        dbg_xfer(1'b1, 32'h40, 32'h1234_5678);
        dbg_xfer(1'b0, 32'h40, 32'h0);
        idle(1);
        cpu_we = 1'b0; cpu_byte = 1'b0; cpu_half = 1'b0;
        cpu_addr = 32'h10; cpu_req = 1'b1;
        dbg_we = 1'b0; dbg_addr = 32'h40; dbg_req = 1'b1;
        win = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (dbg_req && dbg_gnt && win < 0) win = k;
            @(posedge clk);
            #1;
            if (win >= 0) dbg_req = 1'b0;
        end
        cpu_req = 1'b0;
        chk32("starve_win_cycle", 32'(win), 32'(SM));
        idle(1);
        cpu_xfer(1'b0, 1'b0, 1'b0, 1'b0, 32'h13, 32'h0);
        idle(2);
        clr_misalign = 1'b1; idle(1);
        clr_misalign = 1'b0; idle(1);
        clr_misalign = 1'b1;
        cpu_xfer(1'b0, 1'b0, 1'b1, 1'b0, 32'h21, 32'h0);
        clr_misalign = 1'b0; idle(1);
        clr_misalign = 1'b1; idle(1);
        clr_misalign = 1'b0;
        cpu_xfer(1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        CLR_n = 1'b0;
        cpu_xfer(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'hCAFE_F00D);
        CLR_n = 1'b1;
        idle(1);
        cpu_xfer(1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        idle(1);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            cg  = cpu_req && !cpu_stall;
            dgg = dbg_req && dbg_gnt;
            @(posedge clk);
            #1;
            if (!cpu_req || cg) begin
                sz        = int'($urandom_range(2, 0));
                cpu_req   = ($urandom_range(9, 0) < 7);
                cpu_we    = 1'($urandom_range(1, 0));
                cpu_byte  = (sz == 0);
                cpu_half  = (sz == 1);
                cpu_uext  = 1'($urandom_range(1, 0));
                cpu_addr  = $urandom;
                cpu_wdata = $urandom;
            end
            if (!dbg_req || dgg || $urandom_range(7, 0) == 0) begin
                dbg_req   = ($urandom_range(9, 0) < 5);
                dbg_we    = 1'($urandom_range(1, 0));
                dbg_addr  = $urandom;
                dbg_wdata = $urandom;
            end
            clr_misalign = ($urandom_range(7, 0) == 0);
            CLR_n        = ($urandom_range(149, 0) != 0);
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        clr_misalign = 1'b0; CLR_n = 1'b1;
        idle(3);
        chk32("cpu_q_drained", 32'(cq.size()), 32'h0);
        chk32("dbg_q_drained", 32'(dq.size()), 32'h0);
        for (int i = 0; i < 256; i++)
            chk32($sformatf("mem[%0d]", i), {24'h0, ram_m[i]},
                  {24'h0, ref_m[i]});
        $display("== %0d vectors applied, %0d miscompares ==",
                 nchk, nerr);
        $finish;
    end

endmodule
